// File: rtl/mul_tree_sched_if.sv
// Requester, tree and response bundle for mul_tree_sched.
//   req_*  : NREQ requesters (valid/ready handshake, operands, wanted mode)
//   tree_* : issue port towards mul_tree_bf16 and its result port back
//   rsp_*  : in-order result return with owner id
// master = scheduler side, slave = requesters/tree/consumer side.
interface mul_tree_sched_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 32,
    parameter int unsigned IN_W = 128
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*IN_W-1:0] req_data;
    logic [NREQ*2-1:0]    req_mode;

    logic [IN_W-1:0]      tree_ins;
    logic                 tree_stb;
    logic [1:0]           tree_mode;
    logic [4*DW-1:0]      tree_outputs;
    logic [3:0]           tree_out_stbs;

    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [4*DW-1:0]      rsp_data;
    logic [3:0]           rsp_lanes;

    modport master (
        input  req_valid, req_data, req_mode, tree_outputs, tree_out_stbs,
        output req_ready, tree_ins, tree_stb, tree_mode,
        output rsp_valid, rsp_id, rsp_data, rsp_lanes
    );

    modport slave (
        output req_valid, req_data, req_mode, tree_outputs, tree_out_stbs,
        input  req_ready, tree_ins, tree_stb, tree_mode,
        input  rsp_valid, rsp_id, rsp_data, rsp_lanes
    );
endinterface

// File: rtl/mul_tree_sched.sv
// Round-robin scheduler of NREQ requesters onto the single mul_tree_bf16 input port.
// Keeps the tree mode stable while anything is in flight, tags every issue with its
// requester id and returns tree results to their owners in issue order.
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-low reset
//   bus            mul_tree_sched_if.master: requester handshake, tree port, response
//   in_flight      issued-but-not-retired count
//   busy           FSM not idle or operations outstanding
//   err_unexp      sticky: tree result strobe seen with no outstanding tag
module mul_tree_sched #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DW        = 32,
    parameter int unsigned IN_W      = 128,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    mul_tree_sched_if.master        bus,
    output logic [$clog2(DEPTH):0]  in_flight,
    output logic                    busy,
    output logic                    err_unexp
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned BW  = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, SWITCH} state_e;

    state_e             state_q, state_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]      burst_q, burst_d;
    logic [1:0]         next_mode_q, next_mode_d;
    logic [1:0]         tree_mode_q, tree_mode_d;
    logic [CW-1:0]      in_flight_q;
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [IDW-1:0]     tag_mem_q [DEPTH];
    logic               tree_stb_q;
    logic [IN_W-1:0]    tree_ins_q;
    logic               rsp_valid_q;
    logic [IDW-1:0]     rsp_id_q;
    logic [4*DW-1:0]    rsp_data_q;
    logic [3:0]         rsp_lanes_q;
    logic               err_q;

    logic [1:0]         mode_a [NREQ];
    logic [NREQ-1:0]    elig_m, oth_m, grant_vec;
    logic [IDW-1:0]     grant_idx, win_idx, elig_idx, oth_idx;
    logic               win_ok, elig_ok, oth_ok;
    logic               push, pop, unexp;
    logic [IN_W-1:0]    tree_ins_sel;

    // First set bit of mask at or after ptr, wrapping modulo NREQ; returns {found, idx}.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] mask,
                                             input logic [IDW-1:0]  ptr);
        logic           found;
        logic [IDW-1:0] idx;
        int unsigned    j;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            j = (32'(ptr) + i) % NREQ;
            if (!found && mask[j[IDW-1:0]]) begin
                found = 1'b1;
                idx   = j[IDW-1:0];
            end
        end
        return {found, idx};
    endfunction

    // Per-requester mode split against the mode currently loaded in the tree.
    always_comb begin
        elig_m = '0;
        oth_m  = '0;
        for (int i = 0; i < NREQ; i++) begin
            mode_a[i] = bus.req_mode[2*i +: 2];
            elig_m[i] = bus.req_valid[i] && (mode_a[i] == tree_mode_q);
            oth_m[i]  = bus.req_valid[i] && (mode_a[i] != tree_mode_q);
        end
    end

    assign {win_ok,  win_idx}  = rr_pick(bus.req_valid, rr_ptr_q);
    assign {elig_ok, elig_idx} = rr_pick(elig_m, rr_ptr_q);
    assign {oth_ok,  oth_idx}  = rr_pick(oth_m, rr_ptr_q);

    // A result strobe retires the oldest tag; with nothing outstanding it is an error.
    assign pop   = (|bus.tree_out_stbs) && (in_flight_q != '0);
    assign unexp = (|bus.tree_out_stbs) && (in_flight_q == '0);

    // Next-state, grant and mode control.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        burst_d     = burst_q;
        next_mode_d = next_mode_q;
        tree_mode_d = tree_mode_q;
        grant_vec   = '0;
        grant_idx   = '0;
        push        = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_ok) begin
                    if (mode_a[win_idx] == tree_mode_q) begin
                        state_d = RUN;
                    end else begin
                        state_d     = SWITCH;
                        next_mode_d = mode_a[win_idx];
                    end
                end
            end
            RUN: begin
                // Another mode waits and we either starve it or ran out of burst budget.
                if (oth_ok && (!elig_ok || burst_q == BW'(MAX_BURST))) begin
                    state_d     = DRAIN;
                    next_mode_d = mode_a[oth_idx];
                end else begin
                    if (elig_ok && in_flight_q < CW'(DEPTH)) begin
                        push                = 1'b1;
                        grant_idx           = elig_idx;
                        grant_vec[elig_idx] = 1'b1;
                        rr_ptr_d = (32'(elig_idx) == NREQ - 1) ? '0 : elig_idx + 1'b1;
                        if (burst_q != BW'(MAX_BURST)) begin
                            burst_d = burst_q + 1'b1;
                        end
                    end
                    if (!win_ok && in_flight_q == '0) begin
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                // Leave as soon as the last tag retires, including a retire this cycle.
                if (in_flight_q == '0 || (in_flight_q == CW'(1) && pop)) begin
                    state_d = SWITCH;
                end
            end
            SWITCH: begin
                tree_mode_d = next_mode_q;
                burst_d     = '0;
                state_d     = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand mux for the granted requester.
    always_comb begin
        tree_ins_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_vec[i]) begin
                tree_ins_sel = bus.req_data[i*IN_W +: IN_W];
            end
        end
    end

    // State, tag FIFO, issue and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            burst_q     <= '0;
            next_mode_q <= '0;
            tree_mode_q <= '0;
            in_flight_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_mem_q[i] <= '0;
            end
            tree_stb_q  <= 1'b0;
            tree_ins_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_lanes_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_q     <= burst_d;
            next_mode_q <= next_mode_d;
            tree_mode_q <= tree_mode_d;
            tree_stb_q  <= push;
            rsp_valid_q <= pop;
            if (push) begin
                tree_ins_q          <= tree_ins_sel;
                tag_mem_q[wr_ptr_q] <= grant_idx;
                wr_ptr_q            <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rsp_id_q    <= tag_mem_q[rd_ptr_q];
                rsp_data_q  <= bus.tree_outputs;
                rsp_lanes_q <= bus.tree_out_stbs;
                rd_ptr_q    <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   in_flight_q <= in_flight_q + 1'b1;
                2'b01:   in_flight_q <= in_flight_q - 1'b1;
                default: in_flight_q <= in_flight_q;
            endcase
            if (unexp) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.req_ready = grant_vec;
    assign bus.tree_ins  = tree_ins_q;
    assign bus.tree_stb  = tree_stb_q;
    assign bus.tree_mode = tree_mode_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_lanes = rsp_lanes_q;
    assign in_flight     = in_flight_q;
    assign busy          = (state_q != IDLE) || (in_flight_q != '0);
    assign err_unexp     = err_q;
endmodule

// File: tb/tb_mul_tree_sched.sv
// Directed bench for mul_tree_sched with a fixed-latency tree stand-in.
module tb_mul_tree_sched;
    localparam int unsigned NREQ      = 4;
    localparam int unsigned DW        = 32;
    localparam int unsigned IN_W      = 128;
    localparam int unsigned DEPTH     = 16;
    localparam int unsigned MAX_BURST = 8;
    localparam int unsigned L         = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] in_flight;
    logic       busy;
    logic       err_unexp;

    mul_tree_sched_if #(.NREQ(NREQ), .DW(DW), .IN_W(IN_W)) bus ();

    mul_tree_sched #(
        .NREQ(NREQ), .DW(DW), .IN_W(IN_W), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus.master),
        .in_flight(in_flight), .busy(busy), .err_unexp(err_unexp)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          ret_n = 0;
    int          rsp_n = 0;
    logic        auto_ret = 1'b0;
    logic [L-1:0] pipe = '0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [IN_W-1:0] dat(input int i);
        return {4{32'hA000_0000 + 32'(i)}};
    endfunction

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Advance one cycle; the tree stand-in returns each issue L-1 cycles after tree_stb.
    task automatic tick();
        @(posedge clk);
        #1;
        pipe = {pipe[L-2:0], bus.tree_stb};
        if (auto_ret && pipe[L-1]) begin
            bus.tree_out_stbs = 4'hF;
            bus.tree_outputs  = {96'd0, 32'(ret_n)};
            ret_n++;
        end else begin
            bus.tree_out_stbs = 4'h0;
        end
        #1;
    endtask

    task automatic chk_rsp();
        if (bus.rsp_valid) begin
            chk("t1_rsp_id", 128'(bus.rsp_id), 128'(rsp_n % 4));
            chk("t1_rsp_data", bus.rsp_data, 128'(rsp_n));
            rsp_n++;
        end
    endtask

    task automatic do_reset();
        auto_ret          = 1'b0;
        bus.req_valid     = '0;
        bus.req_mode      = '0;
        bus.tree_out_stbs = '0;
        bus.tree_outputs  = '0;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    int infl_hist [200];
    int run_own [8];
    int run_len [8];
    int nruns, cur_own, cur_len, g;
    int exp_id [5] = '{1, 2, 3, 0, 1};
    logic [3:0] ln;

    initial begin
        for (int i = 0; i < NREQ; i++) bus.req_data[i*IN_W +: IN_W] = dat(i);
        do_reset();
        // reset state (sampled while rst was held low, now just released)
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_inflight", 128'(in_flight), 128'(0));
        chk("rst_mode", 128'(bus.tree_mode), 128'(0));
        chk("rst_stb", 128'(bus.tree_stb), 128'(0));
        chk("rst_err", 128'(err_unexp), 128'(0));

        // ---- 1: all four valid, mode 3, round-robin one grant per cycle
        pipe = '0; auto_ret = 1'b1; ret_n = 0; rsp_n = 0;
        bus.req_mode  = 8'hFF;
        bus.req_valid = 4'hF;
        tick();
        chk("t1_switch_ready", 128'(bus.req_ready), 128'(0));
        chk("t1_switch_busy", 128'(busy), 128'(1));
        tick();
        chk("t1_mode", 128'(bus.tree_mode), 128'(3));
        chk("t1_grant0", 128'(bus.req_ready), 128'(1));
        for (int j = 1; j <= 24; j++) begin
            tick();
            chk("t1_grant", 128'(bus.req_ready), 128'(4'b1 << (j % 4)));
            chk("t1_stb", 128'(bus.tree_stb), 128'(1));
            chk("t1_ins", bus.tree_ins, dat((j - 1) % 4));
            chk_rsp();
        end
        bus.req_valid = '0;
        for (int i = 0; i < 60 && (busy || in_flight != 0); i++) begin
            tick();
            chk_rsp();
        end
        chk("t1_idle", 128'(busy), 128'(0));
        chk("t1_rsp_count", 128'(rsp_n), 128'(24));
        chk("t1_err", 128'(err_unexp), 128'(0));

        // ---- 2: two modes contend, bursts of MAX_BURST with drain + one switch cycle
        do_reset();
        pipe = '0; auto_ret = 1'b1;
        bus.req_mode  = 8'b0000_0111;
        bus.req_valid = 4'b0011;
        nruns = 0; cur_own = -1; cur_len = 0;
        for (int i = 0; i < 8; i++) begin run_own[i] = -1; run_len[i] = 0; end
        for (int c = 0; c < 120; c++) begin
            tick();
            infl_hist[c] = int'(in_flight);
            g = oh_idx(bus.req_ready);
            if (g >= 0) begin
                chk("t2_mode", 128'(bus.tree_mode), 128'((g == 0) ? 3 : 1));
                if (g != cur_own) begin
                    if (cur_own >= 0) begin
                        if (nruns < 8) begin
                            run_own[nruns] = cur_own;
                            run_len[nruns] = cur_len;
                            nruns++;
                        end
                        chk("t2_switch_cycle_empty", 128'(infl_hist[c-1]), 128'(0));
                        chk("t2_drain_until_retire", 128'(infl_hist[c-2] != 0), 128'(1));
                    end
                    cur_own = g;
                    cur_len = 0;
                end
                cur_len++;
            end
        end
        for (int r = 0; r < 4; r++) begin
            chk("t2_run_owner", 128'(run_own[r]), 128'(r % 2));
            chk("t2_run_len", 128'(run_len[r]), 128'(MAX_BURST));
        end
        bus.req_valid = '0;
        for (int i = 0; i < 80 && busy; i++) tick();
        chk("t2_idle", 128'(busy), 128'(0));

        // ---- 3: tree stalls results, grant blocked at DEPTH
        do_reset();
        bus.req_mode  = '0;
        bus.req_valid = 4'b0001;
        tick();
        chk("t3_first_grant", 128'(bus.req_ready), 128'(1));
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("t3_grant", 128'(bus.req_ready), 128'(1));
        end
        tick();
        chk("t3_full_inflight", 128'(in_flight), 128'(16));
        chk("t3_full_ready", 128'(bus.req_ready), 128'(0));
        tick();
        chk("t3_still_blocked", 128'(bus.req_ready), 128'(0));
        bus.tree_out_stbs = 4'b0001;
        #1;
        chk("t3_blocked_on_pop", 128'(bus.req_ready), 128'(0));
        tick();
        chk("t3_pop_inflight", 128'(in_flight), 128'(15));
        chk("t3_regrant", 128'(bus.req_ready), 128'(1));
        chk("t3_stb_low", 128'(bus.tree_stb), 128'(0));
        chk("t3_rsp_valid", 128'(bus.rsp_valid), 128'(1));
        chk("t3_rsp_id", 128'(bus.rsp_id), 128'(0));
        chk("t3_rsp_lanes", 128'(bus.rsp_lanes), 128'(4'b0001));
        tick();
        chk("t3_stb_2cyc", 128'(bus.tree_stb), 128'(1));
        chk("t3_refull", 128'(in_flight), 128'(16));
        chk("t3_ready_again_0", 128'(bus.req_ready), 128'(0));
        chk("t3_rsp_pulse", 128'(bus.rsp_valid), 128'(0));
        tick();
        chk("t3_one_grant_only", 128'(bus.tree_stb), 128'(0));

        // ---- 4: retire and issue together at in_flight=5, order preserved
        do_reset();
        bus.req_mode  = '0;
        bus.req_valid = 4'hF;
        tick();
        chk("t4_grant0", 128'(bus.req_ready), 128'(1));
        repeat (5) tick();
        chk("t4_inflight5", 128'(in_flight), 128'(5));
        chk("t4_grant1", 128'(bus.req_ready), 128'(4'b0010));
        bus.tree_out_stbs = 4'b0001;
        tick();
        chk("t4_still5", 128'(in_flight), 128'(5));
        chk("t4_rsp_valid", 128'(bus.rsp_valid), 128'(1));
        chk("t4_rsp_id0", 128'(bus.rsp_id), 128'(0));
        bus.req_valid = '0;
        for (int i = 0; i < 5; i++) begin
            ln = 4'(i + 2);
            bus.tree_out_stbs = ln;
            bus.tree_outputs  = 128'(i + 100);
            tick();
            chk("t4_rsp_valid_n", 128'(bus.rsp_valid), 128'(1));
            chk("t4_rsp_id_n", 128'(bus.rsp_id), 128'(exp_id[i]));
            chk("t4_rsp_lanes_n", 128'(bus.rsp_lanes), 128'(ln));
            chk("t4_rsp_data_n", bus.rsp_data, 128'(i + 100));
        end
        chk("t4_empty", 128'(in_flight), 128'(0));
        tick();
        chk("t4_idle", 128'(busy), 128'(0));

        // ---- 5: unexpected result while idle, then async reset mid-burst
        bus.tree_out_stbs = 4'b0001;
        tick();
        chk("t5_no_rsp", 128'(bus.rsp_valid), 128'(0));
        chk("t5_err_set", 128'(err_unexp), 128'(1));
        chk("t5_inflight", 128'(in_flight), 128'(0));
        tick();
        chk("t5_err_sticky", 128'(err_unexp), 128'(1));
        bus.req_mode  = 8'b0000_0010;
        bus.req_valid = 4'b0001;
        repeat (4) tick();
        chk("t5_burst_mode", 128'(bus.tree_mode), 128'(2));
        chk("t5_burst_stb", 128'(bus.tree_stb), 128'(1));
        chk("t5_burst_inflight", 128'(in_flight), 128'(2));
        #3;
        rst = 1'b0;
        #1;
        chk("t5_arst_stb", 128'(bus.tree_stb), 128'(0));
        chk("t5_arst_ins", bus.tree_ins, 128'(0));
        chk("t5_arst_mode", 128'(bus.tree_mode), 128'(0));
        chk("t5_arst_inflight", 128'(in_flight), 128'(0));
        chk("t5_arst_busy", 128'(busy), 128'(0));
        chk("t5_arst_err", 128'(err_unexp), 128'(0));
        chk("t5_arst_ready", 128'(bus.req_ready), 128'(0));
        chk("t5_arst_rsp_data", bus.rsp_data, 128'(0));
        chk("t5_arst_rsp_lanes", 128'(bus.rsp_lanes), 128'(0));
        tick();
        rst = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
